// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit that owns the HI/LO register pair.
// An operation takes WIDTH+1 cycles from the start edge: WIDTH CALC cycles
// (one product/quotient bit per cycle), then one FIX cycle that applies the
// sign correction and writes HI/LO.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   start, op     : begin MULT(00)/MULTU(01)/DIV(10)/DIVU(11), sampled when idle
//   a, b          : rs / rt operands, sampled with start
//   mt, mt_data   : move-to request (10 -> HI, 11 -> LO), honoured only when idle
//   mf, mf_data   : combinational move-from read (10 -> HI, 11 -> LO, else 0)
//   hi, lo        : HI/LO registers
//   busy          : operation in flight
//   done          : one-cycle pulse after HI/LO were written by an operation
//   dz            : divide-by-zero flag of the last operation
//   stall         : busy & (start | mf[1] | mt[1]), freezes the front pipeline
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mt,
    input  logic [WIDTH-1:0] mt_data,
    input  logic [1:0]       mf,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    state_t           state_r;
    logic [1:0]       op_r;
    logic             sign_a_r;
    logic             sign_b_r;
    logic             div_zero_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] acc_r;      // product upper half / partial remainder
    logic [WIDTH-1:0] low_r;      // multiplier -> product lower half / dividend -> quotient
    logic [WIDTH-1:0] opb_r;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;
    logic             dz_r;

    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic               sign_a_s;
    logic               sign_b_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH+1:0]   diff_s;
    logic [WIDTH-1:0]   acc_next_s;
    logic [WIDTH-1:0]   low_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    // Operand magnitudes and signs; unsigned ops pass raw values through.
    always_comb begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
        if (op[0] == 1'b0) begin
            sign_a_s = a[WIDTH-1];
            sign_b_s = b[WIDTH-1];
        end else begin
            sign_a_s = 1'b0;
            sign_b_s = 1'b0;
        end
        a_mag_s = sign_a_s ? -a : a;
        b_mag_s = sign_b_s ? -b : b;
    end

    // One iteration step: LSB-first shift-add multiply or restoring divide.
    always_comb begin
        sum_s      = {1'b0, acc_r} + (low_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
        shifted_s  = {acc_r, low_r[WIDTH-1]};
        // Two guard bits keep the borrow exact even for a zero divisor, where
        // the quotient fills with ones and the remainder collects the dividend.
        diff_s     = {1'b0, shifted_s} - {2'b00, opb_r};
        acc_next_s = acc_r;
        low_next_s = low_r;
        if (op_r[1] == 1'b0) begin
            acc_next_s = sum_s[WIDTH:1];
            low_next_s = {sum_s[0], low_r[WIDTH-1:1]};
        end else if (diff_s[WIDTH+1] == 1'b0) begin
            acc_next_s = diff_s[WIDTH-1:0];
            low_next_s = {low_r[WIDTH-2:0], 1'b1};
        end else begin
            acc_next_s = shifted_s[WIDTH-1:0];
            low_next_s = {low_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        prod_s   = {acc_r, low_r};
        fix_hi_s = acc_r;
        fix_lo_s = low_r;
        if (op_r[1] == 1'b0) begin
            if ((op_r[0] == 1'b0) && (sign_a_r ^ sign_b_r)) begin
                prod_s = -{acc_r, low_r};
            end else begin
                prod_s = {acc_r, low_r};
            end
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end else begin
            // Remainder follows the dividend; with a zero divisor it equals |a|,
            // so this restores the original a in HI.
            fix_hi_s = sign_a_r ? -acc_r : acc_r;
            if (div_zero_r) begin
                fix_lo_s = {WIDTH{1'b1}};
            end else if (sign_a_r ^ sign_b_r) begin
                fix_lo_s = -low_r;
            end else begin
                fix_lo_s = low_r;
            end
        end
    end

    // Control FSM, datapath registers and HI/LO ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            op_r       <= 2'b00;
            sign_a_r   <= 1'b0;
            sign_b_r   <= 1'b0;
            div_zero_r <= 1'b0;
            count_r    <= {CW{1'b0}};
            acc_r      <= {WIDTH{1'b0}};
            low_r      <= {WIDTH{1'b0}};
            opb_r      <= {WIDTH{1'b0}};
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dz_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        // start wins over a coincident move-to
                        op_r       <= op;
                        sign_a_r   <= sign_a_s;
                        sign_b_r   <= sign_b_s;
                        div_zero_r <= op[1] && (b == {WIDTH{1'b0}});
                        count_r    <= {CW{1'b0}};
                        acc_r      <= {WIDTH{1'b0}};
                        low_r      <= op[1] ? a_mag_s : b_mag_s;
                        opb_r      <= op[1] ? b_mag_s : a_mag_s;
                        dz_r       <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= CALC;
                    end else if (mt == 2'b10) begin
                        hi_r <= mt_data;
                    end else if (mt == 2'b11) begin
                        lo_r <= mt_data;
                    end else begin
                        hi_r <= hi_r;
                    end
                end
                CALC: begin
                    acc_r   <= acc_next_s;
                    low_r   <= low_next_s;
                    count_r <= count_r + 1'b1;
                    if (count_r == LAST_COUNT) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    dz_r    <= div_zero_r;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    count_r <= {CW{1'b0}};
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Move-from read port.
    always_comb begin
        mf_data = {WIDTH{1'b0}};
        if (mf == 2'b10) begin
            mf_data = hi_r;
        end else if (mf == 2'b11) begin
            mf_data = lo_r;
        end else begin
            mf_data = {WIDTH{1'b0}};
        end
    end

    assign stall = busy_r & (start | mf[1] | mt[1]);
    assign hi    = hi_r;
    assign lo    = lo_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign dz    = dz_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Bench for muldiv_unit at WIDTH=32 (scoreboarded) and WIDTH=8 (inline).
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b, mt_data, mf_data, hi, lo;
    logic [1:0]  mt, mf;
    logic        busy, done, dz, stall;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, mf_data8, hi8, lo8;
    logic        busy8, done8, dz8, stall8;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mt(mt), .mt_data(mt_data), .mf(mf), .mf_data(mf_data),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .dz(dz), .stall(stall)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .mt(2'b00), .mt_data(8'h00), .mf(2'b00), .mf_data(mf_data8),
        .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .dz(dz8), .stall(stall8)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic with native 64-bit operators.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        exp_t        e;
        longint      la, lb, q, r;
        logic [63:0] p;
        la = longint'($signed(av));
        lb = longint'($signed(bv));
        e.dz = 1'b0;
        e.name = "rand";
        case (o)
            2'b00: begin p = la * lb; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = {32'h0, av} * {32'h0, bv}; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b10: begin
                if (bv == 32'h0) begin e.hi = av; e.lo = 32'hFFFFFFFF; e.dz = 1'b1; end
                else begin q = la / lb; r = la % lb; e.hi = r[31:0]; e.lo = q[31:0]; end
            end
            default: begin
                if (bv == 32'h0) begin e.hi = av; e.lo = 32'hFFFFFFFF; e.dz = 1'b1; end
                else begin e.hi = av % bv; e.lo = av / bv; end
            end
        endcase
        return e;
    endfunction

    // Scoreboard: compare HI/LO/dz with the oldest expectation on each done.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
                check({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
                check({mon_e.name, "_dz"}, 64'(dz), 64'(mon_e.dz));
            end
        end
    end

    // Issue one op at the current negedge and wait for its done, checking timing.
    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input exp_t e);
        int cyc;
        int busy_cnt;
        start = 1'b1; op = o; a = av; b = bv;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check({e.name, "_busy_rise"}, 64'(busy), 64'd1);
        cyc = 0;
        busy_cnt = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
        end
        check({e.name, "_latency"}, 64'(cyc), 64'd33);
        check({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({e.name, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ehi, input logic [7:0] elo, input string name);
        int cyc;
        start8 = 1'b1; op8 = o; a8 = av; b8 = bv;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc), 64'd9);
        check({name, "_hi"}, 64'(hi8), 64'(ehi));
        check({name, "_lo"}, 64'(lo8), 64'(elo));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[11];
        exp_t e;
        int   dcnt;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        tbl[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        tbl[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[5]  = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
        tbl[6]  = '{2'b01, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0};
        tbl[7]  = '{2'b10, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0};
        tbl[8]  = '{2'b10, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1};
        tbl[9]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[10] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

        rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
        mt = 2'b00; mt_data = 32'h0; mf = 2'b00;
        start8 = 1'b0; op8 = 2'b00; a8 = 8'h0; b8 = 8'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(dz), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);

        // Move-to while idle, then move-from
        mt = 2'b10; mt_data = 32'h00001234;
        @(negedge clk);
        mt = 2'b11; mt_data = 32'h00005678; mf = 2'b10;
        #1 check("mf_hi", 64'(mf_data), 64'h1234);
        @(negedge clk);
        mt = 2'b00; mf = 2'b11;
        #1 check("mf_lo", 64'(mf_data), 64'h5678);
        mf = 2'b01;
        #1 check("mf_none", 64'(mf_data), 64'd0);
        mf = 2'b00;

        // start with a coincident mt: only the op result lands in LO
        mt = 2'b11; mt_data = 32'hDEADBEEF;
        #1 check("stall_idle", 64'(stall), 64'd0);
        e = '{32'h00000001, 32'h23450000, 1'b0, "start_mt"};
        fork
            run_op(2'b01, 32'h00012345, 32'h00010000, e);
            begin
                @(negedge clk);
                mt = 2'b00;
                check("start_mt_lo_kept", 64'(lo), 64'h5678);
            end
        join

        // Handshake: start+mf+mt mid-operation
        e = '{32'h00000001, 32'h00000000, 1'b0, "hs"};
        fork
            run_op(2'b01, 32'h00010000, 32'h00010000, e);
            begin
                repeat (6) @(negedge clk);
                start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
                mf = 2'b10; mt = 2'b11; mt_data = 32'hCAFEF00D;
                #1;
                check("hs_stall", 64'(stall), 64'd1);
                check("hs_mf_prev", 64'(mf_data), 64'h1);
                @(negedge clk);
                start = 1'b0; mf = 2'b00; mt = 2'b00;
                check("hs_lo_unchanged", 64'(lo), 64'h23450000);
            end
        join
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("hs_second_start_ignored", 64'(dcnt), 64'd0);

        // Table vectors, issued back to back in each done cycle
        for (int i = 0; i < 11; i++) begin
            e = '{tbl[i].hi, tbl[i].lo, tbl[i].dz, $sformatf("vec%0d", i)};
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, e);
        end

        // Random vectors against the native-arithmetic model
        for (int i = 0; i < 20; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            e = model(ro, ra, rb);
            e.name = $sformatf("rand%0d", i);
            run_op(ro, ra, rb, e);
        end

        // Reset mid-DIV aborts with no write
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);

        // WIDTH=8 instance
        run8(2'b00, 8'h80, 8'h80, 8'h40, 8'h00, "w8_mult");
        run8(2'b10, 8'h80, 8'hFF, 8'h00, 8'h80, "w8_div_ovf");
        run8(2'b11, 8'hC8, 8'h07, 8'h04, 8'h1C, "w8_divu");
        run8(2'b01, 8'hFF, 8'hFF, 8'hFE, 8'h01, "w8_multu");

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
